risk_check_ctrl: RTL and testbench
==================================

// Module: risk_check_ctrl
// PURPOSE
//  Sequencer for the pre-trade risk check: accepts one order (client_id, amount) at a time and reads the client's entry from the limit table.
//  It computes future exposure, compares it against the client's max, writes back accumulated on pass, and returns pass/fail.
//  Sits between the order-ingress path and the per-client limit RAM (1-cycle read latency).
// PARAMETERS
//  CLIENT_W  8   client id width; table depth 2**CLIENT_W
//  VAL_W     32  width of amount/max/accumulated/reduced (unsigned pounds)
// PORTS
//  clk             in   1          single clock, rising edge
//  rst             in   1          synchronous, active-high reset
//  req_valid       in   1          order request valid
//  req_ready       out  1          controller can accept (IDLE only)
//  req_client_id   in   CLIENT_W   client / table line
//  req_amount      in   VAL_W      order amount
//  cfg_block_all   in   1          kill switch: force fail, no table write
//  resp_valid      out  1          result valid, held until resp_ready
//  resp_ready      in   1          downstream accepts result
//  resp_pass       out  1          1 = pass, 0 = fail
//  resp_client_id  out  CLIENT_W   id of the order being answered
//  mem_rd_en       out  1          table read strobe
//  mem_rd_addr     out  CLIENT_W   table read address
//  mem_rd_data     in   3*VAL_W    {max, accumulated, reduced}, valid 1 cycle after mem_rd_en
//  mem_wr_en       out  1          table write strobe
//  mem_wr_addr     out  CLIENT_W   table write address
//  mem_wr_data     out  3*VAL_W    {max, accumulated', reduced}
//  stat_pass_cnt   out  32         passes counted (see CONFIGURATION)
//  stat_fail_cnt   out  32         fails counted (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_pass=0, resp_client_id=0, mem_rd_en=0, mem_wr_en=0, addrs/data=0, stat counters=0.
//  - FSM: IDLE -(req_valid&&req_ready)-> RD -> EVAL -> WB -> RESP -(resp_ready)-> IDLE.
//  - Transitions are unconditional except where noted.
//  - IDLE: req_ready=1; on accept, latch client_id, amount, and cfg_block_all.
//  - RD: mem_rd_en=1, mem_rd_addr=latched id. Exactly one cycle.
//  - EVAL: sample mem_rd_data; compute in VAL_W+1 bits: sum = accumulated + amount.
//      future = (sum >= reduced) ? sum - reduced : 0.
//      pass = !blk && !sum[VAL_W] && (future <= max).
//      Register pass and new_acc = sum[VAL_W-1:0].
//  - WB: mem_wr_en = pass for one cycle, addr = latched id, data = {max, new_acc, reduced}.
//      No write on fail, block, or overflow.
//  - RESP: resp_valid=1 with stable resp_pass/resp_client_id until resp_ready. No new request accepted.
//  - Latency: accept at edge 0; resp_valid high in cycle 4; req_ready back the cycle after the resp handshake.
//  - Overflow: sum carry (sum[VAL_W]=1) -> fail, no write.
//  - Boundary: future == max passes; max == 0 passes only if future == 0.
//  - cfg_block_all is sampled at accept only; mid-transaction changes do not affect the current order.
//  - Reset mid-operation: abort to IDLE; no write, no response; table untouched.
//  - resp_ready held high in IDLE is ignored; resp_ready low stalls indefinitely in RESP.
// CONFIGURATION
//  RISK_STATS_EN defined: stat_pass_cnt/stat_fail_cnt increment once per completed resp handshake, saturating at 2**32-1.
//  RISK_STATS_EN undefined: counters not built; both ports tied to 0.
// STRUCTURE
//  risk_pkg: CLIENT_W/VAL_W defaults; typedef risk_entry_t {max, accumulated, reduced}; enum risk_state_e {IDLE,RD,EVAL,WB,RESP}.
//  Sub-module risk_exposure_calc (combinational): entry + amount + blk -> pass, new_acc.
//  Instantiated once in EVAL.
// TESTING
//  1 table[3]={max=1000,acc=400,red=100}; req id=3 amt=600 -> resp_pass=1 at cycle 4; write {1000,1000,100} to addr 3.
//  2 same entry, amt=701 -> future=1001 -> resp_pass=0; mem_wr_en never asserted.
//  3 acc=2**32-10, red=0, max=2**32-1, amt=20 -> carry -> fail, no write.
//  4 red=500 > acc+amt=300 -> future=0 -> pass for max=0.
//  5 cfg_block_all=1 at accept, then 0 -> fail, no write; resp_ready low 5 cycles -> resp held stable, req_ready=0 throughout.
//  6 rst in EVAL -> next cycle IDLE, no write, no resp; with RISK_STATS_EN, 3 pass + 2 fail handshakes -> counters 3/2.

Source files
------------

// File: rtl/risk_pkg.sv
// Shared types and default widths for the pre-trade risk check controller.
package risk_pkg;

  localparam int DEF_CLIENT_W = 8;
  localparam int DEF_VAL_W    = 32;

  // One limit-table line, packed MSB-first as {max, accumulated, reduced}.
  typedef struct packed {
    logic [DEF_VAL_W-1:0] max;
    logic [DEF_VAL_W-1:0] accumulated;
    logic [DEF_VAL_W-1:0] reduced;
  } risk_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EVAL,
    WB,
    RESP
  } risk_state_e;

endpackage

// File: rtl/risk_exposure_calc.sv
// Combinational exposure check: adds the order to accumulated exposure, nets off
// reductions and compares against the client's limit.
module risk_exposure_calc #(
  parameter int VAL_W = 32
) (
  input  logic [VAL_W-1:0] max,
  input  logic [VAL_W-1:0] accumulated,
  input  logic [VAL_W-1:0] reduced,
  input  logic [VAL_W-1:0] amount,
  input  logic             blk,
  output logic             pass,
  output logic [VAL_W-1:0] new_acc
);

  logic [VAL_W:0] sum;
  logic [VAL_W:0] future;

  // One extra bit so a wrapped sum is caught as overflow instead of looking small.
  assign sum     = {1'b0, accumulated} + {1'b0, amount};
  assign future  = (sum >= {1'b0, reduced}) ? (sum - {1'b0, reduced}) : '0;
  assign pass    = !blk && !sum[VAL_W] && (future <= {1'b0, max});
  assign new_acc = sum[VAL_W-1:0];

endmodule

// File: rtl/risk_check_ctrl.sv
// Pre-trade risk check sequencer: one order at a time through RD/EVAL/WB/RESP
// against a 1-cycle-latency limit RAM. Optional counters under RISK_STATS_EN.
module risk_check_ctrl
  import risk_pkg::*;
#(
  parameter int CLIENT_W = DEF_CLIENT_W,
  parameter int VAL_W    = DEF_VAL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CLIENT_W-1:0]   req_client_id,
  input  logic [VAL_W-1:0]      req_amount,
  input  logic                  cfg_block_all,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_pass,
  output logic [CLIENT_W-1:0]   resp_client_id,
  output logic                  mem_rd_en,
  output logic [CLIENT_W-1:0]   mem_rd_addr,
  input  logic [3*VAL_W-1:0]    mem_rd_data,
  output logic                  mem_wr_en,
  output logic [CLIENT_W-1:0]   mem_wr_addr,
  output logic [3*VAL_W-1:0]    mem_wr_data,
  output logic [31:0]           stat_pass_cnt,
  output logic [31:0]           stat_fail_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid and its payload stay stable until that edge.

  risk_state_e         state;
  logic [CLIENT_W-1:0] lat_id;
  logic [VAL_W-1:0]    lat_amount;
  logic                lat_blk;

  logic [VAL_W-1:0]    rd_max;
  logic [VAL_W-1:0]    rd_acc;
  logic [VAL_W-1:0]    rd_red;
  logic                calc_pass;
  logic [VAL_W-1:0]    calc_new_acc;

  assign rd_max = mem_rd_data[3*VAL_W-1:2*VAL_W];
  assign rd_acc = mem_rd_data[2*VAL_W-1:VAL_W];
  assign rd_red = mem_rd_data[VAL_W-1:0];

  risk_exposure_calc #(
    .VAL_W (VAL_W)
  ) u_calc (
    .max         (rd_max),
    .accumulated (rd_acc),
    .reduced     (rd_red),
    .amount      (lat_amount),
    .blk         (lat_blk),
    .pass        (calc_pass),
    .new_acc     (calc_new_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_pass      <= 1'b0;
      resp_client_id <= '0;
      mem_rd_en      <= 1'b0;
      mem_rd_addr    <= '0;
      mem_wr_en      <= 1'b0;
      mem_wr_addr    <= '0;
      mem_wr_data    <= '0;
      lat_id         <= '0;
      lat_amount     <= '0;
      lat_blk        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_id      <= req_client_id;
            lat_amount  <= req_amount;
            lat_blk     <= cfg_block_all;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= req_client_id;
            req_ready   <= 1'b0;
            state       <= RD;
          end
        end
        RD: begin
          mem_rd_en <= 1'b0;
          state     <= EVAL;
        end
        EVAL: begin
          // Write strobe is the pass bit itself: fail, block and overflow never touch the table.
          resp_pass   <= calc_pass;
          mem_wr_en   <= calc_pass;
          mem_wr_addr <= lat_id;
          mem_wr_data <= {rd_max, calc_new_acc, rd_red};
          state       <= WB;
        end
        WB: begin
          mem_wr_en      <= 1'b0;
          resp_valid     <= 1'b1;
          resp_client_id <= lat_id;
          state          <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RISK_STATS_EN
  logic [31:0] pass_cnt;
  logic [31:0] fail_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (resp_valid && resp_ready) begin
      if (resp_pass) begin
        if (pass_cnt != 32'hFFFF_FFFF) pass_cnt <= pass_cnt + 32'd1;
      end else begin
        if (fail_cnt != 32'hFFFF_FFFF) fail_cnt <= fail_cnt + 32'd1;
      end
    end
  end

  assign stat_pass_cnt = pass_cnt;
  assign stat_fail_cnt = fail_cnt;
`else
  assign stat_pass_cnt = '0;
  assign stat_fail_cnt = '0;
`endif

endmodule

// File: tb/tb_risk_check_ctrl.sv
// Directed bench for risk_check_ctrl with a behavioural limit RAM (1-cycle read).
// Counter checks follow RISK_STATS_EN.
module tb_risk_check_ctrl;
  import risk_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_client_id;
  logic [31:0] req_amount;
  logic        cfg_block_all;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_pass;
  logic [7:0]  resp_client_id;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [95:0] mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_addr;
  logic [95:0] mem_wr_data;
  logic [31:0] stat_pass_cnt;
  logic [31:0] stat_fail_cnt;

  int tests_run;
  int tests_failed;
  int wr_count;

  logic [95:0] mem_model [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [95:0] pl_data;

  risk_check_ctrl u_dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_client_id  (req_client_id),
    .req_amount     (req_amount),
    .cfg_block_all  (cfg_block_all),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_pass      (resp_pass),
    .resp_client_id (resp_client_id),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .stat_pass_cnt  (stat_pass_cnt),
    .stat_fail_cnt  (stat_fail_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Limit RAM model: registered read, write on strobe, bench preload port.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_model[mem_rd_addr];
    if (mem_wr_en) begin
      mem_model[mem_wr_addr] <= mem_wr_data;
      wr_count <= wr_count + 1;
    end else if (pl_en) begin
      mem_model[pl_addr] <= pl_data;
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] ent(input logic [31:0] mx, input logic [31:0] acc,
                                      input logic [31:0] red);
    risk_entry_t e;
    e.max         = mx;
    e.accumulated = acc;
    e.reduced     = red;
    return e;
  endfunction

  task automatic preload(input logic [7:0] addr, input logic [95:0] data);
    pl_en   = 1'b1;
    pl_addr = addr;
    pl_data = data;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  // Driver: one full order, checking every phase of the fixed-latency sequence.
  task automatic do_order(input logic [7:0] id, input logic [31:0] amt, input logic blk,
                          input logic exp_pass, input int stall, input logic [95:0] exp_wdata);
    int wr0;
    wr0 = wr_count;
    check("idle_ready", req_ready, 1'b1);
    req_valid     = 1'b1;
    req_client_id = id;
    req_amount    = amt;
    cfg_block_all = blk;
    resp_ready    = (stall == 0);
    @(posedge clk); #1;
    req_valid     = 1'b0;
    req_client_id = 8'(id + 8'd1);
    req_amount    = 32'(amt + 32'd1);
    cfg_block_all = !blk;
    check("rd_en", mem_rd_en, 1'b1);
    check("rd_addr", mem_rd_addr, id);
    check("busy_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    check("eval_rd_off", mem_rd_en, 1'b0);
    @(posedge clk); #1;
    check("wb_wr_en", mem_wr_en, exp_pass);
    if (exp_pass) begin
      check("wb_addr", mem_wr_addr, id);
      check("wb_data", mem_wr_data, exp_wdata);
    end
    @(posedge clk); #1;
    check("resp_valid", resp_valid, 1'b1);
    check("resp_pass", resp_pass, exp_pass);
    check("resp_id", resp_client_id, id);
    check("resp_wr_off", mem_wr_en, 1'b0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", resp_valid, 1'b1);
      check("stall_pass", resp_pass, exp_pass);
      check("stall_id", resp_client_id, id);
      check("stall_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("done_valid", resp_valid, 1'b0);
    check("done_ready", req_ready, 1'b1);
    resp_ready    = 1'b0;
    cfg_block_all = 1'b0;
    check("write_count", wr_count - wr0, exp_pass ? 1 : 0);
  endtask

  initial begin
    int wr0;
    tests_run     = 0;
    tests_failed  = 0;
    wr_count      = 0;
    pl_en         = 1'b0;
    pl_addr       = '0;
    pl_data       = '0;
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_client_id = '0;
    req_amount    = '0;
    cfg_block_all = 1'b0;
    resp_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_pass", resp_pass, 1'b0);
    check("rst_resp_id", resp_client_id, 8'd0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_wr_en", mem_wr_en, 1'b0);
    check("rst_rd_addr", mem_rd_addr, 8'd0);
    check("rst_wr_addr", mem_wr_addr, 8'd0);
    check("rst_wr_data", mem_wr_data, 96'd0);
    check("rst_pass_cnt", stat_pass_cnt, 32'd0);
    check("rst_fail_cnt", stat_fail_cnt, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 400+600-100 = 900 <= 1000; resp_ready already high in IDLE.
    preload(8'd3, ent(32'd1000, 32'd400, 32'd100));
    do_order(8'd3, 32'd600, 1'b0, 1'b1, 0, ent(32'd1000, 32'd1000, 32'd100));
    check("tbl3_after_pass", mem_model[3], ent(32'd1000, 32'd1000, 32'd100));

    // 400+701-100 = 1001 > 1000.
    preload(8'd3, ent(32'd1000, 32'd400, 32'd100));
    do_order(8'd3, 32'd701, 1'b0, 1'b0, 0, '0);
    check("tbl3_after_fail", mem_model[3], ent(32'd1000, 32'd400, 32'd100));

    // future == max exactly.
    do_order(8'd3, 32'd700, 1'b0, 1'b1, 1, ent(32'd1000, 32'd1100, 32'd100));

    // Carry out of the 32-bit sum.
    preload(8'd5, ent(32'hFFFF_FFFF, 32'hFFFF_FFF6, 32'd0));
    do_order(8'd5, 32'd20, 1'b0, 1'b0, 0, '0);

    // Reductions exceed sum: future clamps to 0, passes with max=0.
    preload(8'd7, ent(32'd0, 32'd100, 32'd500));
    do_order(8'd7, 32'd200, 1'b0, 1'b1, 0, ent(32'd0, 32'd300, 32'd500));

    // max=0 with future=1 fails.
    preload(8'd8, ent(32'd0, 32'd100, 32'd299));
    do_order(8'd8, 32'd200, 1'b0, 1'b0, 0, '0);

    // Kill switch at accept, deasserted afterwards, response stalled 5 cycles.
    preload(8'd9, ent(32'd1000, 32'd0, 32'd0));
    do_order(8'd9, 32'd10, 1'b1, 1'b0, 5, '0);

    // Reset while in EVAL aborts the order.
    preload(8'd10, ent(32'd1000, 32'd0, 32'd0));
    wr0           = wr_count;
    req_valid     = 1'b1;
    req_client_id = 8'd10;
    req_amount    = 32'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", req_ready, 1'b1);
    check("abort_resp", resp_valid, 1'b0);
    check("abort_wr_en", mem_wr_en, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_idle_resp", resp_valid, 1'b0);
      check("abort_idle_rd", mem_rd_en, 1'b0);
    end
    check("abort_writes", wr_count - wr0, 0);
    check("abort_tbl", mem_model[10], ent(32'd1000, 32'd0, 32'd0));

    // Three passes and two fails after the reset.
    preload(8'd11, ent(32'd1000, 32'd0, 32'd0));
    do_order(8'd11, 32'd10, 1'b0, 1'b1, 0, ent(32'd1000, 32'd10, 32'd0));
    do_order(8'd11, 32'd10, 1'b0, 1'b1, 2, ent(32'd1000, 32'd20, 32'd0));
    do_order(8'd11, 32'd2000, 1'b0, 1'b0, 0, '0);
    do_order(8'd11, 32'd10, 1'b0, 1'b1, 0, ent(32'd1000, 32'd30, 32'd0));
    do_order(8'd11, 32'd5, 1'b1, 1'b0, 1, '0);
    check("tbl11_final", mem_model[11], ent(32'd1000, 32'd30, 32'd0));
`ifdef RISK_STATS_EN
    check("stat_pass", stat_pass_cnt, 32'd3);
    check("stat_fail", stat_fail_cnt, 32'd2);
`else
    check("stat_pass_off", stat_pass_cnt, 32'd0);
    check("stat_fail_off", stat_fail_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
